// File: rtl/pcpi_pkg.sv
// Shared types and constants for both ends of the PCPI coprocessor link.
package pcpi_pkg;

    localparam int         PCPI_XLEN            = 32;
    localparam logic [6:0] PCPI_OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] PCPI_FUNCT7_MULDIV   = 7'b0000001;
    localparam int         PCPI_DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } pcpi_init_state_t;

    typedef struct packed {
        logic                 wr;
        logic                 trap;
        logic [PCPI_XLEN-1:0] rd;
    } pcpi_rsp_t;

    function automatic logic is_muldiv(input logic [31:0] insn);
        return (insn[6:0] == PCPI_OPCODE_OP) && (insn[31:25] == PCPI_FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/pcpi_timeout_timer.sv
// Down-counter that flags expiry in the cycle its count is 1; load has priority over dec.
// Saturates at zero so a stray dec after expiry cannot wrap back to a large value.
module pcpi_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic expire
);
    localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LOAD_VAL = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_count <= LOAD_VAL;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - TW'(1);
        end
    end

    assign expire = (r_count == TW'(1));

endmodule

// File: rtl/pcpi_initiator.sv
// CPU-side PCPI initiator: one request in flight, pcpi_valid one cycle after accept, response
// buffered until rsp_ready; req_ready only in IDLE, trap after TIMEOUT_CYCLES silent cycles.
module pcpi_initiator
    import pcpi_pkg::*;
#(
    parameter int XLEN           = PCPI_XLEN,
    parameter int TIMEOUT_CYCLES = PCPI_DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_insn,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic            abort,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_wr,
    output logic [XLEN-1:0] rsp_rd,
    output logic            rsp_trap,
    output logic            pcpi_valid,
    output logic [31:0]     pcpi_insn,
    output logic [XLEN-1:0] pcpi_rs1,
    output logic [XLEN-1:0] pcpi_rs2,
    input  logic            pcpi_ready,
    input  logic            pcpi_wr,
    input  logic [XLEN-1:0] pcpi_rd,
    input  logic            pcpi_busy
);
    pcpi_init_state_t r_state;
    pcpi_init_state_t w_state_nxt;

    logic w_accept;
    logic w_done;
    logic w_trap;
    logic w_abort;
    logic w_release;
    logic w_tmr_load;
    logic w_tmr_dec;
    logic w_expire;

    logic            r_pcpi_valid;
    logic [31:0]     r_pcpi_insn;
    logic [XLEN-1:0] r_pcpi_rs1;
    logic [XLEN-1:0] r_pcpi_rs2;
    logic            r_rsp_valid;
    logic            r_rsp_wr;
    logic            r_rsp_trap;
    logic [XLEN-1:0] r_rsp_rd;

    pcpi_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (w_tmr_load),
        .dec   (w_tmr_dec),
        .expire(w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ISSUE priority: abort, then ready, then busy, then the timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        w_trap      = 1'b0;
        w_abort     = 1'b0;
        w_release   = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept    = 1'b1;
                    w_tmr_load  = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (abort) begin
                    w_abort     = 1'b1;
                    w_state_nxt = IDLE;
                end else if (pcpi_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = RESP;
                end else if (pcpi_busy) begin
                    w_tmr_load  = 1'b1;
                end else begin
                    w_tmr_dec = 1'b1;
                    if (w_expire) begin
                        w_trap      = 1'b1;
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcpi_valid <= 1'b0;
            r_pcpi_insn  <= '0;
            r_pcpi_rs1   <= '0;
            r_pcpi_rs2   <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_wr     <= 1'b0;
            r_rsp_trap   <= 1'b0;
            r_rsp_rd     <= '0;
        end else begin
            if (w_accept) begin
                r_pcpi_valid <= 1'b1;
                r_pcpi_insn  <= req_insn;
                r_pcpi_rs1   <= req_rs1;
                r_pcpi_rs2   <= req_rs2;
            end
            if (w_abort) begin
                r_pcpi_valid <= 1'b0;
            end
            if (w_done) begin
                r_pcpi_valid <= 1'b0;
                r_rsp_valid  <= 1'b1;
                r_rsp_wr     <= pcpi_wr;
                r_rsp_rd     <= pcpi_rd;
                r_rsp_trap   <= 1'b0;
            end
            if (w_trap) begin
                r_pcpi_valid <= 1'b0;
                r_rsp_valid  <= 1'b1;
                r_rsp_wr     <= 1'b0;
                r_rsp_rd     <= '0;
                r_rsp_trap   <= 1'b1;
            end
            if (w_release) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign req_ready  = (r_state == IDLE);
    assign pcpi_valid = r_pcpi_valid;
    assign pcpi_insn  = r_pcpi_insn;
    assign pcpi_rs1   = r_pcpi_rs1;
    assign pcpi_rs2   = r_pcpi_rs2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_wr     = r_rsp_wr;
    assign rsp_rd     = r_rsp_rd;
    assign rsp_trap   = r_rsp_trap;

endmodule

// File: tb/tb_pcpi_initiator.sv
// Bench for pcpi_initiator: directed scenarios plus randomized transactions scored against
// a cycle-count model of the issue/timeout/abort rules.
module tb_pcpi_initiator;
    localparam int XLEN = 32;
    localparam int TO   = 16;

    logic            clk        = 1'b0;
    logic            reset      = 1'b1;
    logic            req_valid  = 1'b0;
    logic            req_ready;
    logic [31:0]     req_insn   = '0;
    logic [XLEN-1:0] req_rs1    = '0;
    logic [XLEN-1:0] req_rs2    = '0;
    logic            abort      = 1'b0;
    logic            rsp_valid;
    logic            rsp_ready  = 1'b0;
    logic            rsp_wr;
    logic [XLEN-1:0] rsp_rd;
    logic            rsp_trap;
    logic            pcpi_valid;
    logic [31:0]     pcpi_insn;
    logic [XLEN-1:0] pcpi_rs1;
    logic [XLEN-1:0] pcpi_rs2;
    logic            pcpi_ready = 1'b0;
    logic            pcpi_wr    = 1'b0;
    logic [XLEN-1:0] pcpi_rd    = '0;
    logic            pcpi_busy  = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    pcpi_initiator #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_insn(req_insn),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .abort(abort),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rd(rsp_rd), .rsp_trap(rsp_trap),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1),
        .pcpi_rs2(pcpi_rs2), .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr),
        .pcpi_rd(pcpi_rd), .pcpi_busy(pcpi_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    // Protocol monitor: operands frozen while pcpi_valid, and pcpi_valid never alongside a response.
    int              proto_viol = 0;
    logic            p_valid    = 1'b0;
    logic [31:0]     p_insn     = '0;
    logic [XLEN-1:0] p_rs1      = '0;
    logic [XLEN-1:0] p_rs2      = '0;
    always @(negedge clk) begin
        if ((p_valid && pcpi_valid && (pcpi_insn !== p_insn || pcpi_rs1 !== p_rs1 || pcpi_rs2 !== p_rs2))
            || (pcpi_valid && rsp_valid))
            proto_viol <= proto_viol + 1;
        p_valid <= pcpi_valid;
        p_insn  <= pcpi_insn;
        p_rs1   <= pcpi_rs1;
        p_rs2   <= pcpi_rs2;
    end

    // Reference model. kind: 0 aborted, 1 normal response, 2 trap. vcyc: cycles pcpi_valid is high.
    function automatic void model(input int ready_at, input int busy_until, input int abort_at,
                                  output int kind, output int vcyc);
        int idle = 0;
        kind = 3;
        vcyc = 0;
        for (int k = 1; k <= 1000; k++) begin
            if (k == abort_at) begin kind = 0; vcyc = k; return; end
            if (k == ready_at) begin kind = 1; vcyc = k; return; end
            if (k <= busy_until) idle = 0;
            else idle++;
            if (idle == TO) begin kind = 2; vcyc = k; return; end
        end
    endfunction

    int              obs_kind, obs_vcyc;
    logic            obs_wr, obs_trap;
    logic [XLEN-1:0] obs_rd;
    bit              obs_stable, obs_rr_low, obs_ops_ok, obs_accepted, obs_after_rr, obs_after_rv;

    // Drives one request and plays the responder; records what it saw, compares nothing.
    task automatic run_txn(input logic [31:0] insn, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input int ready_at, input int busy_until, input int abort_at,
                           input logic wr, input logic [XLEN-1:0] rd, input int hold, input bit keep_req);
        int k;
        bit done;
        obs_kind = 0; obs_vcyc = 0; obs_stable = 1; obs_rr_low = 1; obs_ops_ok = 1;
        obs_wr = 1'bx; obs_trap = 1'bx; obs_rd = 'x;
        @(negedge clk);
        obs_accepted = req_ready;
        req_valid = 1'b1; req_insn = insn; req_rs1 = a; req_rs2 = b;
        @(posedge clk);
        k = 1;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (!keep_req) req_valid = 1'b0;
            if (rsp_valid === 1'b1) begin
                done = 1;
                obs_kind = (rsp_trap === 1'b1) ? 2 : 1;
            end else if (k > 300) begin
                done = 1;
                obs_kind = 3;
            end else begin
                if (pcpi_valid === 1'b1) begin
                    obs_vcyc++;
                    if (pcpi_insn !== insn || pcpi_rs1 !== a || pcpi_rs2 !== b) obs_ops_ok = 0;
                end
                if (abort_at != 0 && k > abort_at && k > ready_at + 2) begin
                    done = 1;
                end else begin
                    pcpi_ready = (k == ready_at);
                    pcpi_busy  = (k <= busy_until);
                    abort      = (k == abort_at);
                    pcpi_wr    = wr;
                    pcpi_rd    = rd;
                    k++;
                end
            end
        end
        pcpi_ready = 1'b0; pcpi_busy = 1'b0; abort = 1'b0;
        if (obs_kind == 1 || obs_kind == 2) begin
            obs_wr = rsp_wr; obs_rd = rsp_rd; obs_trap = rsp_trap;
            if (req_ready !== 1'b0) obs_rr_low = 0;
            for (int h = 0; h < hold; h++) begin
                rsp_ready = 1'b0;
                abort     = 1'b1;
                @(posedge clk);
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_wr !== obs_wr || rsp_rd !== obs_rd || rsp_trap !== obs_trap)
                    obs_stable = 0;
                if (req_ready !== 1'b0 || pcpi_valid !== 1'b0) obs_rr_low = 0;
            end
            abort     = 1'b0;
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        obs_after_rr = req_ready;
        obs_after_rv = rsp_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (pcpi_valid !== 1'b0) begin n_err++; $display("FAIL rst_pcpi_valid: got %b want 0", pcpi_valid); end
        n_cmp++; if ({pcpi_insn, pcpi_rs1, pcpi_rs2} !== '0) begin n_err++; $display("FAIL rst_pcpi_regs: got %h/%h/%h want 0", pcpi_insn, pcpi_rs1, pcpi_rs2); end
        n_cmp++; if ({rsp_valid, rsp_wr, rsp_trap} !== 3'b000) begin n_err++; $display("FAIL rst_rsp_flags: got %b want 000", {rsp_valid, rsp_wr, rsp_trap}); end
        n_cmp++; if (rsp_rd !== '0) begin n_err++; $display("FAIL rst_rsp_rd: got %h want 0", rsp_rd); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
        reset = 1'b0;
    endtask

    task automatic test_mul();
        logic [XLEN-1:0] a = 7, b = 6;
        run_txn(32'h02B50533, a, b, 3, 0, 0, 1'b1, a * b, 0, 0);
        n_cmp++; if (obs_accepted !== 1'b1) begin n_err++; $display("FAIL mul_accept: got %b want 1", obs_accepted); end
        n_cmp++; if (obs_kind !== 1) begin n_err++; $display("FAIL mul_kind: got %0d want 1", obs_kind); end
        n_cmp++; if (obs_vcyc !== 3) begin n_err++; $display("FAIL mul_valid_cycles: got %0d want 3", obs_vcyc); end
        n_cmp++; if ({obs_wr, obs_trap} !== 2'b10) begin n_err++; $display("FAIL mul_wr_trap: got %b want 10", {obs_wr, obs_trap}); end
        n_cmp++; if (obs_rd !== 32'd42) begin n_err++; $display("FAIL mul_rd: got %0d want 42", obs_rd); end
        n_cmp++; if (obs_ops_ok !== 1'b1) begin n_err++; $display("FAIL mul_operands: got %b want 1", obs_ops_ok); end
        n_cmp++; if ({obs_after_rr, obs_after_rv} !== 2'b10) begin n_err++; $display("FAIL mul_release: got %b want 10", {obs_after_rr, obs_after_rv}); end
    endtask

    task automatic test_timeout();
        logic [XLEN-1:0] v = $urandom | 32'h1;
        run_txn($urandom, $urandom, $urandom, 0, 0, 0, 1'b1, v, 0, 0);
        n_cmp++; if (obs_kind !== 2) begin n_err++; $display("FAIL to_kind: got %0d want 2", obs_kind); end
        n_cmp++; if (obs_vcyc !== TO) begin n_err++; $display("FAIL to_valid_cycles: got %0d want %0d", obs_vcyc, TO); end
        n_cmp++; if ({obs_wr, obs_trap} !== 2'b01) begin n_err++; $display("FAIL to_wr_trap: got %b want 01", {obs_wr, obs_trap}); end
        n_cmp++; if (obs_rd !== '0) begin n_err++; $display("FAIL to_rd: got %h want 0", obs_rd); end
        run_txn($urandom, $urandom, $urandom, TO, 0, 0, 1'b1, v, 0, 0);
        n_cmp++; if (obs_kind !== 1) begin n_err++; $display("FAIL to_edge_kind: got %0d want 1", obs_kind); end
        n_cmp++; if (obs_vcyc !== TO) begin n_err++; $display("FAIL to_edge_valid_cycles: got %0d want %0d", obs_vcyc, TO); end
        n_cmp++; if (obs_rd !== v) begin n_err++; $display("FAIL to_edge_rd: got %h want %h", obs_rd, v); end
    endtask

    task automatic test_busy();
        run_txn($urandom, $urandom, $urandom, 41, 40, 0, 1'b1, 32'hFFFFFFFF, 0, 0);
        n_cmp++; if (obs_kind !== 1) begin n_err++; $display("FAIL busy_kind: got %0d want 1", obs_kind); end
        n_cmp++; if (obs_vcyc !== 41) begin n_err++; $display("FAIL busy_valid_cycles: got %0d want 41", obs_vcyc); end
        n_cmp++; if (obs_rd !== 32'hFFFFFFFF) begin n_err++; $display("FAIL busy_rd: got %h want ffffffff", obs_rd); end
        n_cmp++; if (obs_trap !== 1'b0) begin n_err++; $display("FAIL busy_trap: got %b want 0", obs_trap); end
    endtask

    task automatic test_backpressure();
        logic [31:0]     insn2 = $urandom;
        logic [XLEN-1:0] v     = $urandom;
        run_txn($urandom, $urandom, $urandom, 2, 0, 0, 1'b0, v, 5, 1);
        n_cmp++; if (obs_stable !== 1'b1) begin n_err++; $display("FAIL bp_stable: got %b want 1", obs_stable); end
        n_cmp++; if (obs_rr_low !== 1'b1) begin n_err++; $display("FAIL bp_req_ready_low: got %b want 1", obs_rr_low); end
        n_cmp++; if (obs_rd !== v) begin n_err++; $display("FAIL bp_rd: got %h want %h", obs_rd, v); end
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after: got %b want 1", req_ready); end
        req_insn = insn2;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_cmp++; if (pcpi_valid !== 1'b1 || pcpi_insn !== insn2) begin n_err++; $display("FAIL bp_next_issue: got %b/%h want 1/%h", pcpi_valid, pcpi_insn, insn2); end
        pcpi_ready = 1'b1; pcpi_wr = 1'b0; pcpi_rd = ~v;
        @(posedge clk);
        @(negedge clk);
        pcpi_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_rd !== ~v || rsp_wr !== 1'b0) begin n_err++; $display("FAIL bp_next_rsp: got %b/%h/%b want 1/%h/0", rsp_valid, rsp_rd, rsp_wr, ~v); end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_abort();
        run_txn($urandom, $urandom, $urandom, 3, 0, 2, 1'b1, $urandom, 0, 0);
        n_cmp++; if (obs_kind !== 0) begin n_err++; $display("FAIL abort_kind: got %0d want 0", obs_kind); end
        n_cmp++; if (obs_vcyc !== 2) begin n_err++; $display("FAIL abort_valid_cycles: got %0d want 2", obs_vcyc); end
        n_cmp++; if ({obs_after_rr, obs_after_rv} !== 2'b10) begin n_err++; $display("FAIL abort_idle: got %b want 10", {obs_after_rr, obs_after_rv}); end
    endtask

    task automatic test_reset_mid_issue();
        bit seen = 0;
        @(negedge clk);
        req_valid = 1'b1; req_insn = $urandom | 32'h1; req_rs1 = $urandom; req_rs2 = $urandom;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; pcpi_busy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (pcpi_valid !== 1'b1) begin n_err++; $display("FAIL rmid_in_issue: got %b want 1", pcpi_valid); end
        reset = 1'b1; pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = $urandom | 32'h1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; pcpi_busy = 1'b0;
        n_cmp++; if (pcpi_valid !== 1'b0) begin n_err++; $display("FAIL rmid_pcpi_valid: got %b want 0", pcpi_valid); end
        n_cmp++; if ({rsp_valid, rsp_wr, rsp_trap} !== 3'b000 || rsp_rd !== '0) begin n_err++; $display("FAIL rmid_rsp: got %b/%h want 000/0", {rsp_valid, rsp_wr, rsp_trap}, rsp_rd); end
        n_cmp++; if (pcpi_insn !== '0) begin n_err++; $display("FAIL rmid_insn: got %h want 0", pcpi_insn); end
        for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            @(negedge clk);
            pcpi_ready = 1'b0;
            if (rsp_valid !== 1'b0 || pcpi_valid !== 1'b0) seen = 1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rmid_no_response: got %b want 0", seen); end
    endtask

    task automatic test_random();
        int ready_at, busy_until, abort_at, hold, ekind, evcyc;
        logic [XLEN-1:0] v;
        logic            w;
        for (int t = 0; t < 40; t++) begin
            ready_at   = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 30));
            busy_until = $urandom_range(0, 20);
            abort_at   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 20)) : 0;
            hold       = $urandom_range(0, 4);
            v          = $urandom;
            w          = 1'($urandom);
            model(ready_at, busy_until, abort_at, ekind, evcyc);
            run_txn($urandom, $urandom, $urandom, ready_at, busy_until, abort_at, w, v, hold, 0);
            n_cmp++; if (obs_kind !== ekind) begin n_err++; $display("FAIL rnd%0d_kind: got %0d want %0d (r=%0d b=%0d a=%0d)", t, obs_kind, ekind, ready_at, busy_until, abort_at); end
            n_cmp++; if (obs_vcyc !== evcyc) begin n_err++; $display("FAIL rnd%0d_valid_cycles: got %0d want %0d", t, obs_vcyc, evcyc); end
            n_cmp++; if (obs_ops_ok !== 1'b1) begin n_err++; $display("FAIL rnd%0d_operands: got %b want 1", t, obs_ops_ok); end
            if (ekind == 1) begin
                n_cmp++; if ({obs_wr, obs_trap, obs_rd} !== {w, 1'b0, v}) begin n_err++; $display("FAIL rnd%0d_rsp: got %b/%b/%h want %b/0/%h", t, obs_wr, obs_trap, obs_rd, w, v); end
            end else if (ekind == 2) begin
                n_cmp++; if ({obs_wr, obs_trap, obs_rd} !== {1'b0, 1'b1, {XLEN{1'b0}}}) begin n_err++; $display("FAIL rnd%0d_trap: got %b/%b/%h want 0/1/0", t, obs_wr, obs_trap, obs_rd); end
            end
            if (ekind != 0) begin
                n_cmp++; if ({obs_stable, obs_rr_low} !== 2'b11) begin n_err++; $display("FAIL rnd%0d_hold: got %b want 11", t, {obs_stable, obs_rr_low}); end
            end
            n_cmp++; if ({obs_after_rr, obs_after_rv} !== 2'b10) begin n_err++; $display("FAIL rnd%0d_idle_after: got %b want 10", t, {obs_after_rr, obs_after_rv}); end
        end
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 3; t++) begin
            run_txn($urandom, $urandom, $urandom, 1, 0, 0, 1'b1, 32'(t + 100), 0, 0);
            n_cmp++; if (obs_accepted !== 1'b1 || obs_vcyc !== 1) begin n_err++; $display("FAIL b2b%0d_latency: got acc=%b vcyc=%0d want acc=1 vcyc=1", t, obs_accepted, obs_vcyc); end
            n_cmp++; if (obs_rd !== 32'(t + 100)) begin n_err++; $display("FAIL b2b%0d_rd: got %0d want %0d", t, obs_rd, t + 100); end
        end
    endtask

    task automatic test_protocol();
        n_cmp++; if (proto_viol !== 0) begin n_err++; $display("FAIL protocol: got %0d violations want 0", proto_viol); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_timeout();
        test_busy();
        test_backpressure();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_mid_issue();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pcpi_initiator.md
Name: pcpi_initiator

Overview:
- CPU-side end of the PCPI coprocessor interface; the counterpart to the M-unit controller, which is the responder.
- Accepts one custom/M instruction with its operands from the core pipeline and drives pcpi_valid/insn/rs1/rs2 toward the coprocessor.
- Waits for pcpi_ready, or raises a trap on timeout, then holds a buffered response until the core takes it.
- Used by the SoC testbench as a PCPI driver and by the core wrapper as its offload port.

Parameters:
- XLEN, 32, data width of rs1/rs2/rd.
- TIMEOUT_CYCLES, 16, number of consecutive cycles with no pcpi_ready and no pcpi_busy before a trap is raised; legal range 1..255.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents an instruction.
- req_ready  out  1  block accepts the instruction this cycle.
- req_insn  in  32  instruction word.
- req_rs1  in  XLEN  operand 1.
- req_rs2  in  XLEN  operand 2.
- abort  in  1  pipeline flush; cancels the outstanding request.
- rsp_valid  out  1  response buffered.
- rsp_ready  in  1  core consumes the response.
- rsp_wr  out  1  coprocessor requested a register write.
- rsp_rd  out  XLEN  result data.
- rsp_trap  out  1  timeout; treat as an illegal instruction.
- pcpi_valid  out  1  request to the coprocessor.
- pcpi_insn  out  32  registered instruction.
- pcpi_rs1  out  XLEN  registered operand 1.
- pcpi_rs2  out  XLEN  registered operand 2.
- pcpi_ready  in  1  coprocessor done (one cycle).
- pcpi_wr  in  1  sampled only with pcpi_ready.
- pcpi_rd  in  XLEN  sampled only with pcpi_ready.
- pcpi_busy  in  1  coprocessor accepted the instruction and is still working.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - pcpi_valid=0; pcpi_insn, pcpi_rs1 and pcpi_rs2 are cleared to 0.
  - rsp_valid=0, rsp_wr=0, rsp_rd=0, rsp_trap=0.
  - Timer is loaded with TIMEOUT_CYCLES.
  - Reset mid-operation drops everything with no response; pcpi_valid is low in the cycle after reset is sampled.
- State machine: IDLE -> ISSUE -> RESP -> IDLE.
  - All outputs are registered; req_ready is the exception, decoded combinationally as (state==IDLE).
- IDLE:
  - req_ready=1.
  - On req_valid: latch insn/rs1/rs2 into the pcpi_* registers, load timer=TIMEOUT_CYCLES, go to ISSUE.
  - pcpi_valid rises in the next cycle.
- ISSUE:
  - pcpi_valid=1; insn, rs1 and rs2 stay stable the whole time.
  - Priority each cycle is abort > pcpi_ready > pcpi_busy > timer.
  - abort: go to IDLE with no response; any later pcpi_ready is ignored.
  - pcpi_ready: capture rsp_wr=pcpi_wr, rsp_rd=pcpi_rd, rsp_trap=0; go to RESP; pcpi_valid drops in the next cycle.
  - pcpi_busy without ready: reload timer=TIMEOUT_CYCLES.
  - Otherwise the timer decrements.
  - Trap: the timer was 1 in this cycle and none of abort/ready/busy is asserted. Set rsp_trap=1, rsp_wr=0, rsp_rd=0, go to RESP.
  - Trap timing: it is raised after exactly TIMEOUT_CYCLES idle ISSUE cycles.
  - pcpi_ready in the same cycle as expiry wins (normal response, no trap).
- RESP:
  - rsp_valid=1; data is held stable until rsp_ready.
  - req_ready=0.
  - On rsp_ready: go to IDLE and clear rsp_valid.
  - abort is ignored in RESP; the core discards the response itself.
- Minimum latency: accept at cycle 0; pcpi_valid at cycle 1; pcpi_ready at cycle 1; rsp_valid at cycle 2; IDLE again at cycle 3 if rsp_ready is high at cycle 2. At most one request is outstanding.
- Timer:
  - Width is $clog2(TIMEOUT_CYCLES+1).
  - Decrement-only, never wraps below 0.
- Protocol checks (assertions in the bench):
  - pcpi_insn/rs1/rs2 never change while pcpi_valid=1.
  - pcpi_valid is never high in RESP.

Decomposition:
- Shared package pcpi_pkg holds:
  - Typedef pcpi_init_state_t {IDLE, ISSUE, RESP} on 2 bits.
  - Typedef pcpi_rsp_t struct {wr, trap, rd}.
  - Constants PCPI_OPCODE_OP=7'b0110011, PCPI_FUNCT7_MULDIV=7'b0000001, PCPI_DEFAULT_TIMEOUT=16.
- Optional sub-module pcpi_timeout_timer:
  - Ports: clk, reset, load, dec, expire.
  - Parameter: TIMEOUT_CYCLES.

Test Plan:
- MUL issue:
  - Stimulus: req_insn=0x02B50533, rs1=7, rs2=6; responder returns pcpi_ready with wr=1, rd=42 two cycles after pcpi_valid.
  - Required: rsp_valid=1, rsp_wr=1, rsp_rd=42, rsp_trap=0; pcpi_valid high for exactly 3 cycles.
- Timeout:
  - Stimulus: responder never answers; TIMEOUT_CYCLES=16.
  - Required: rsp_trap=1, rsp_wr=0 exactly 16 ISSUE cycles after pcpi_valid rises.
  - Repeat with pcpi_ready on the 16th cycle: normal response, no trap.
- Busy extension:
  - Stimulus: pcpi_busy held for 40 cycles, then pcpi_ready with rd=0xFFFFFFFF.
  - Required: no trap, rsp_rd=0xFFFFFFFF.
- Backpressure:
  - Stimulus: rsp_ready low for 5 cycles; req_valid held high.
  - Required: rsp_* stable throughout, req_ready=0; next request accepted in the cycle after rsp_ready.
- Abort:
  - Stimulus: abort 1 cycle after pcpi_valid, responder ready 1 cycle later.
  - Required: no rsp_valid, state IDLE, req_ready=1.
- Reset mid-ISSUE:
  - Stimulus: reset asserted for 1 cycle while in ISSUE.
  - Required: pcpi_valid=0 and all rsp_* =0 in the next cycle; no response is ever produced.
